// File: rtl/pwg_1557_pkg.sv
// Shared types and default sizes for the pwg_1557 pulse-width generator.
package pwg_1557_pkg;

  localparam int CNT_W_DEF     = 8;
  localparam int REP_W_DEF     = 4;
  localparam int MIN_WIDTH_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } pwg_state_e;

endpackage

// File: rtl/pwg_1557_cnt.sv
// Loadable down-counter that saturates at zero; reports when it has reached zero.
module pwg_1557_cnt #(
  parameter int W = 8
) (
  input  logic         clk11m,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load wins, otherwise step down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk11m) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pwg_1557.sv
// Pulse-width generator: emits rep pulses of hi cycles high / lo cycles low,
// then a one-cycle done strobe. Optional build macro PWG_1557_MIN_WIDTH_CLAMP_EN
// raises short high widths to the minimum that survives the 12-cycle filter.
module pwg_1557
  import pwg_1557_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk11m,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_hi,
  input  logic [CNT_W-1:0] req_lo,
  input  logic [REP_W-1:0] req_rep,
  input  logic             abort,
  output logic             g,
  output logic             busy,
  output logic             done
);

  pwg_state_e       state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic             abort_q, abort_d;
  logic             g_q, g_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [CNT_W-1:0] hi_eff, lo_eff;
  logic             w_load, w_dec, w_zero;
  logic [CNT_W-1:0] w_val;
  logic             r_load, r_dec, r_zero;
  logic [REP_W-1:0] r_val;

  // Promote zero widths to one cycle; optionally clamp the high width upward.
  always_comb begin
    if (req_hi == {CNT_W{1'b0}}) begin
      hi_eff = CNT_W'(1);
    end else begin
      hi_eff = req_hi;
    end
`ifdef PWG_1557_MIN_WIDTH_CLAMP_EN
    if (hi_eff < CNT_W'(MIN_WIDTH_DEF)) begin
      hi_eff = CNT_W'(MIN_WIDTH_DEF);
    end else begin
      hi_eff = hi_eff;
    end
`endif
    if (req_lo == {CNT_W{1'b0}}) begin
      lo_eff = CNT_W'(1);
    end else begin
      lo_eff = req_lo;
    end
  end

  // Sequencer next-state logic; the width counter is shared by HIGH and LOW.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    abort_d = abort_q;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    w_val   = {CNT_W{1'b0}};
    r_load  = 1'b0;
    r_dec   = 1'b0;
    r_val   = {REP_W{1'b0}};
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req_valid) begin
          hi_d = hi_eff;
          lo_d = lo_eff;
          if (req_rep == {REP_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            // First HIGH entry consumes one repeat.
            state_d = HIGH;
            w_load  = 1'b1;
            w_val   = hi_eff - CNT_W'(1);
            r_load  = 1'b1;
            r_val   = req_rep - REP_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (abort || w_zero) begin
          // Aborted pulses still get a full low gap before finishing.
          state_d = LOW;
          w_load  = 1'b1;
          w_val   = lo_q - CNT_W'(1);
          abort_d = abort_q | abort;
        end else begin
          w_dec = 1'b1;
        end
      end
      LOW: begin
        abort_d = abort_q | abort;
        if (w_zero) begin
          if (r_zero || abort_q || abort) begin
            state_d = DONE;
          end else begin
            state_d = HIGH;
            w_load  = 1'b1;
            w_val   = hi_q - CNT_W'(1);
            r_dec   = 1'b1;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    g_d     = (state_d == HIGH);
    busy_d  = (state_d == HIGH) || (state_d == LOW);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk11m) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= {CNT_W{1'b0}};
      lo_q    <= {CNT_W{1'b0}};
      abort_q <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      abort_q <= abort_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  pwg_1557_cnt #(.W(CNT_W)) u_wcnt (
    .clk11m (clk11m),
    .rst    (rst),
    .load   (w_load),
    .dec    (w_dec),
    .val    (w_val),
    .zero   (w_zero)
  );

  pwg_1557_cnt #(.W(REP_W)) u_rcnt (
    .clk11m (clk11m),
    .rst    (rst),
    .load   (r_load),
    .dec    (r_dec),
    .val    (r_val),
    .zero   (r_zero)
  );

  assign g         = g_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_pwg_1557.sv
// Scoreboard bench for pwg_1557: per-cycle expected {g,busy,done,req_ready}
// is queued when a request is driven and compared every cycle afterwards.
module tb_pwg_1557;

  logic       clk11m = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_hi;
  logic [7:0] req_lo;
  logic [3:0] req_rep;
  logic       abort;
  logic       g;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] sb[$];

  localparam logic [3:0] ST_H = 4'b1100;
  localparam logic [3:0] ST_L = 4'b0100;
  localparam logic [3:0] ST_D = 4'b0010;
  localparam logic [3:0] ST_I = 4'b0001;

`ifdef PWG_1557_MIN_WIDTH_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  pwg_1557 dut (
    .clk11m    (clk11m),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_hi    (req_hi),
    .req_lo    (req_lo),
    .req_rep   (req_rep),
    .abort     (abort),
    .g         (g),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk11m = ~clk11m;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got g/busy/done/ready=%b want %b", tag, obs, exp);
    end
  endtask

  // Build the expected per-cycle trace (cycle 1 = first cycle after accept).
  task automatic build_exp(input int hi, input int lo, input int rep,
                           input int abort_at, input int rst_at);
    int hi_e;
    int lo_e;
    int cyc;
    bit stop;
    hi_e = (hi == 0) ? 1 : hi;
    if (CLAMP && hi_e < 13) hi_e = 13;
    lo_e = (lo == 0) ? 1 : lo;
    if (rst_at > 0) begin
      for (int i = 0; i < rst_at; i++) sb.push_back(ST_H);
      sb.push_back(ST_I);
      sb.push_back(ST_I);
      return;
    end
    cyc  = 0;
    stop = 1'b0;
    for (int p = 0; p < rep && !stop; p++) begin
      for (int i = 0; i < hi_e; i++) begin
        cyc++;
        sb.push_back(ST_H);
        if (cyc == abort_at) begin
          stop = 1'b1;
          break;
        end
      end
      for (int i = 0; i < lo_e; i++) begin
        cyc++;
        sb.push_back(ST_L);
        if (cyc == abort_at) stop = 1'b1;
      end
    end
    sb.push_back(ST_D);
    sb.push_back(ST_I);
  endtask

  // Offer one request, then drain the scoreboard one cycle at a time.
  // abort_at: 0 = abort together with the handshake, k>0 = during cycle k, <0 = never.
  task automatic run_req(input int tn, input int hi, input int lo, input int rep,
                         input int abort_at, input int rst_at);
    int idx;
    logic [3:0] exp;
    build_exp(hi, lo, rep, abort_at, rst_at);
    @(negedge clk11m);
    req_valid = 1'b1;
    req_hi    = 8'(hi);
    req_lo    = 8'(lo);
    req_rep   = 4'(rep);
    abort     = (abort_at == 0);
    idx = 0;
    while (sb.size() > 0) begin
      @(negedge clk11m);
      idx++;
      req_valid = 1'b0;
      req_hi    = 8'($urandom);
      req_lo    = 8'($urandom);
      req_rep   = 4'($urandom);
      exp = sb.pop_front();
      chk($sformatf("t%0d.c%0d", tn, idx), {g, busy, done, req_ready}, exp);
      abort = (idx == abort_at);
      rst   = (idx == rst_at);
    end
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_hi    = 8'd0;
    req_lo    = 8'd0;
    req_rep   = 4'd0;
    abort     = 1'b0;
    repeat (2) @(negedge clk11m);
    chk("reset", {g, busy, done, req_ready}, ST_I);
    rst = 1'b0;
    @(negedge clk11m);
    chk("post_reset", {g, busy, done, req_ready}, ST_I);

    run_req(1, 13, 4, 1, -1, 0);    // clean pulse above filter width
    run_req(2, 2, 1, 3, -1, 0);     // short pulses, three repeats
    run_req(3, 0, 0, 2, -1, 0);     // zero widths promoted to one
    run_req(4, 7, 7, 0, -1, 0);     // rep = 0: immediate done
    run_req(5, 5, 2, 2, -1, 3);     // reset during third HIGH cycle
    run_req(6, 5, 2, 1, -1, 0);     // clamp-dependent width
    run_req(7, 5, 2, 1, 2, 0);      // abort in HIGH
    run_req(8, 2, 3, 3, 3, 0);      // abort in LOW
    run_req(9, 3, 2, 2, 0, 0);      // abort with handshake is ignored
    run_req(10, 255, 255, 1, -1, 0); // maximum widths
    run_req(11, 1, 1, 15, -1, 0);   // maximum repeat count
    // abort while idle must not disturb anything
    @(negedge clk11m);
    abort = 1'b1;
    @(negedge clk11m);
    abort = 1'b0;
    chk("idle_abort", {g, busy, done, req_ready}, ST_I);
    run_req(12, 4, 1, 1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
